// File: rtl/apb_master_ctrl_if.sv
// ----------------------------------------------------------------------------
// apb_master_ctrl_if
//   Bundles the command port, the response port and the APB bus of the
//   APB requester into one interface.
//   modport master : view of the requester itself (apb_master_ctrl)
//   modport slave  : view of the environment (command source, response sink
//                    and APB completer)
//   Signals:
//     cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata  command handshake
//     rsp_valid/rsp_rdata/rsp_err/rsp_timeout           one-cycle response
//     PSEL/PENABLE/PWRITE/PADDR/PWDATA                  APB request side
//     PRDATA/PREADY/PSLVERR                             APB completer side
// ----------------------------------------------------------------------------
interface apb_master_ctrl_if #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [AWIDTH-1:0] cmd_addr;
    logic [DWIDTH-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AWIDTH-1:0] PADDR;
    logic [DWIDTH-1:0] PWDATA;
    logic [DWIDTH-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// ----------------------------------------------------------------------------
// apb_master_ctrl
//   APB requester. Takes single read/write commands on a valid/ready port,
//   runs the APB SETUP/ACCESS sequence and returns read data or an error on
//   a one-cycle response strobe. A PREADY wait timeout aborts transfers to a
//   hung completer.
//   Ports:
//     PCLK     clock, rising edge
//     PRESETn  asynchronous reset, active low
//     bus      apb_master_ctrl_if.master (command, response and APB signals)
//   Parameters:
//     AWIDTH   address width
//     DWIDTH   data width
//     TIMEOUT  max ACCESS cycles with PREADY low before abort, 0 = never
// ----------------------------------------------------------------------------
module apb_master_ctrl #(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    apb_master_ctrl_if.master      bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // Counter holds 0..TIMEOUT so it can never wrap before the abort fires.
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            TO_EN    = (TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    logic [1:0]        state_q,       state_d;
    logic              psel_q,        psel_d;
    logic              penable_q,     penable_d;
    logic              pwrite_q,      pwrite_d;
    logic [AWIDTH-1:0] paddr_q,       paddr_d;
    logic [DWIDTH-1:0] pwdata_q,      pwdata_d;
    logic [CW-1:0]     cnt_q,         cnt_d;
    logic              rsp_valid_q,   rsp_valid_d;
    logic [DWIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic              rsp_err_q,     rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    // Next-state and output decode of the SETUP/ACCESS sequencer.
    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        cnt_d         = cnt_q;
        // Response fields default low so each response lasts exactly one cycle.
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = {DWIDTH{1'b0}};
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    pwrite_d  = bus.cmd_write;
                    paddr_d   = bus.cmd_addr;
                    pwdata_d  = bus.cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = {CW{1'b0}};
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.PSLVERR;
                    rsp_rdata_d = pwrite_q ? {DWIDTH{1'b0}} : bus.PRDATA;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    // Counter already shows TIMEOUT-1 completed waits: this
                    // is the TIMEOUT-th ACCESS cycle with PREADY low.
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = ST_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1'b1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops the bus at once.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= {AWIDTH{1'b0}};
            pwdata_q      <= {DWIDTH{1'b0}};
            cnt_q         <= {CW{1'b0}};
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= {DWIDTH{1'b0}};
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // cmd_ready depends on state only, never on cmd_valid.
    assign bus.cmd_ready   = (state_q == ST_IDLE) & PRESETn;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// ----------------------------------------------------------------------------
// tb_apb_master_ctrl
//   Directed bench for apb_master_ctrl (TIMEOUT = 16). Inputs change and
//   outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_master_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    apb_master_ctrl_if #(.AWIDTH(8), .DWIDTH(8)) bus ();

    apb_master_ctrl #(.AWIDTH(8), .DWIDTH(8), .TIMEOUT(16)) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = data;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 8'h00;
        bus.PRDATA    = 8'h00;
        bus.PREADY    = 1'b1;
        bus.PSLVERR   = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_psel",      32'(bus.PSEL),      32'd0);
        check("rst_penable",   32'(bus.PENABLE),   32'd0);
        check("rst_paddr",     32'(bus.PADDR),     32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // 1: write 0x12 <- 0xA5, zero wait states
        issue(1'b1, 8'h12, 8'hA5);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("t1_setup_psel",    32'(bus.PSEL),      32'd1);
        check("t1_setup_penable", 32'(bus.PENABLE),   32'd0);
        check("t1_paddr",         32'(bus.PADDR),     32'h12);
        check("t1_pwdata",        32'(bus.PWDATA),    32'hA5);
        check("t1_pwrite",        32'(bus.PWRITE),    32'd1);
        check("t1_cmd_ready",     32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        check("t1_access_penable", 32'(bus.PENABLE), 32'd1);
        check("t1_access_paddr",   32'(bus.PADDR),   32'h12);
        @(negedge clk);
        check("t1_rsp_valid",   32'(bus.rsp_valid),   32'd1);
        check("t1_rsp_err",     32'(bus.rsp_err),     32'd0);
        check("t1_rsp_rdata",   32'(bus.rsp_rdata),   32'h00);
        check("t1_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        check("t1_psel_drop",   32'(bus.PSEL),        32'd0);
        check("t1_cmd_ready",   32'(bus.cmd_ready),   32'd1);
        @(negedge clk);
        check("t1_rsp_pulse", 32'(bus.rsp_valid), 32'd0);

        // 2: read 0x04, two wait states, data 0x3C
        bus.PREADY = 1'b0;
        bus.PRDATA = 8'hFF;
        issue(1'b0, 8'h04, 8'h00);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("t2_setup_pwrite", 32'(bus.PWRITE), 32'd0);
        check("t2_setup_paddr",  32'(bus.PADDR),  32'h04);
        @(negedge clk);
        check("t2_penable_c1", 32'(bus.PENABLE), 32'd1);
        @(negedge clk);
        check("t2_penable_c2",   32'(bus.PENABLE),   32'd1);
        check("t2_no_rsp_wait",  32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("t2_penable_c3", 32'(bus.PENABLE), 32'd1);
        bus.PREADY = 1'b1;
        bus.PRDATA = 8'h3C;
        @(negedge clk);
        check("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t2_rsp_rdata", 32'(bus.rsp_rdata), 32'h3C);
        check("t2_rsp_err",   32'(bus.rsp_err),   32'd0);
        check("t2_penable",   32'(bus.PENABLE),   32'd0);

        // 3: read with PSLVERR
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 8'h77;
        issue(1'b0, 8'h20, 8'h00);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t3_rsp_valid",   32'(bus.rsp_valid),   32'd1);
        check("t3_rsp_err",     32'(bus.rsp_err),     32'd1);
        check("t3_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        bus.PSLVERR = 1'b0;
        @(negedge clk);
        check("t3_err_pulse", 32'(bus.rsp_err), 32'd0);

        // 4: PREADY held low -> abort after 16 ACCESS cycles
        bus.PREADY = 1'b0;
        bus.PRDATA = 8'h99;
        issue(1'b0, 8'h30, 8'h00);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 16; i++) @(negedge clk);
        check("t4_access16_psel",  32'(bus.PSEL),      32'd1);
        check("t4_access16_norsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("t4_rsp_valid",   32'(bus.rsp_valid),   32'd1);
        check("t4_rsp_err",     32'(bus.rsp_err),     32'd1);
        check("t4_rsp_timeout", 32'(bus.rsp_timeout), 32'd1);
        check("t4_rsp_rdata",   32'(bus.rsp_rdata),   32'h00);
        check("t4_psel",        32'(bus.PSEL),        32'd0);
        check("t4_cmd_ready",   32'(bus.cmd_ready),   32'd1);
        bus.PREADY = 1'b1;
        @(negedge clk);
        check("t4_rsp_pulse", 32'(bus.rsp_valid), 32'd0);

        // 5: four back-to-back writes with cmd_valid held high
        issue(1'b1, 8'h40, 8'h10);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t5_setup%0d_psel", k),    32'(bus.PSEL),      32'd1);
            check($sformatf("t5_setup%0d_penable", k), 32'(bus.PENABLE),   32'd0);
            check($sformatf("t5_setup%0d_paddr", k),   32'(bus.PADDR),     32'h40 + 32'(k));
            check($sformatf("t5_setup%0d_pwdata", k),  32'(bus.PWDATA),    32'h10 + 32'(k));
            check($sformatf("t5_setup%0d_ready", k),   32'(bus.cmd_ready), 32'd0);
            bus.cmd_addr  = 8'h41 + 8'(k);
            bus.cmd_wdata = 8'h11 + 8'(k);
            @(negedge clk);
            check($sformatf("t5_access%0d_penable", k), 32'(bus.PENABLE),   32'd1);
            check($sformatf("t5_access%0d_ready", k),   32'(bus.cmd_ready), 32'd0);
            @(negedge clk);
            check($sformatf("t5_idle%0d_rsp", k),   32'(bus.rsp_valid), 32'd1);
            check($sformatf("t5_idle%0d_ready", k), 32'(bus.cmd_ready), 32'd1);
            check($sformatf("t5_idle%0d_psel", k),  32'(bus.PSEL),      32'd0);
            if (k == 3) bus.cmd_valid = 1'b0;
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("t5_no_fifth%0d", j), 32'(bus.PSEL), 32'd0);
        end

        // 6: reset during an ACCESS wait, then a normal write
        bus.PREADY = 1'b0;
        issue(1'b0, 8'h55, 8'h00);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_in_access", 32'(bus.PENABLE), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_psel",    32'(bus.PSEL),      32'd0);
        check("t6_async_penable", 32'(bus.PENABLE),   32'd0);
        check("t6_async_paddr",   32'(bus.PADDR),     32'd0);
        check("t6_async_pwrite",  32'(bus.PWRITE),    32'd0);
        check("t6_async_ready",   32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        bus.PREADY = 1'b1;
        @(negedge clk);
        check("t6_no_rsp",    32'(bus.rsp_valid), 32'd0);
        check("t6_ready_back", 32'(bus.cmd_ready), 32'd1);
        issue(1'b1, 8'h66, 8'h5A);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("t6_setup_paddr", 32'(bus.PADDR), 32'h66);
        @(negedge clk);
        check("t6_access_penable", 32'(bus.PENABLE), 32'd1);
        @(negedge clk);
        check("t6_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t6_rsp_err",   32'(bus.rsp_err),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
